// File: rtl/oflow_buf_wr_pkg.sv
// Shared types and constants for the overflow buffer write responder.
// Optional wr_parity output is enabled by defining OFLOW_BUF_WR_PARITY_EN.
package oflow_buf_wr_pkg;

  localparam int ROW_LEN    = 3;
  localparam int PE_LEN     = 5;
  localparam int PE_NUM     = 24;
  localparam int GROUP_SIZE = 4;
  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 8;
  localparam int NBOX_W     = 8;

  localparam int NUM_GROUPS_PER_ROW = PE_NUM / GROUP_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  function automatic logic [ADDR_WIDTH-1:0] buf_addr(
    input logic [ROW_LEN-1:0] row,
    input logic [PE_LEN-1:0]  pe
  );
    logic [15:0] a;
    a = 16'(row) * 16'(PE_NUM) + 16'(pe) * 16'(GROUP_SIZE);
    return a[ADDR_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/oflow_buffer_fsm_write_if.sv
// Core request / buffer write bundle for oflow_buffer_fsm_write.
// wr_parity exists only when OFLOW_BUF_WR_PARITY_EN is defined.
interface oflow_buf_wr_if;
  import oflow_buf_wr_pkg::*;

  logic                             ready_from_core;
  logic [ROW_LEN-1:0]               row_sel;
  logic [PE_LEN-1:0]                pe_sel;
  logic [1:0]                       remainder;
  logic [GROUP_SIZE*DATA_WIDTH-1:0] pe_data;
  logic                             wr_en;
  logic [ADDR_WIDTH-1:0]            wr_addr;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic                             done_write_buffer;
`ifdef OFLOW_BUF_WR_PARITY_EN
  logic                             wr_parity;
`endif

  modport master (
    output ready_from_core, row_sel, pe_sel,
    output remainder, pe_data,
    input  wr_en, wr_addr, wr_data,
`ifdef OFLOW_BUF_WR_PARITY_EN
    input  wr_parity,
`endif
    input  done_write_buffer
  );

  modport slave (
    input  ready_from_core, row_sel, pe_sel,
    input  remainder, pe_data,
    output wr_en, wr_addr, wr_data,
`ifdef OFLOW_BUF_WR_PARITY_EN
    output wr_parity,
`endif
    output done_write_buffer
  );

endinterface

// File: rtl/oflow_buf_wr_frame_cnt.sv
// Per-frame bbox counter: accumulate, compare, saturate on overflow.
// frame_done is registered; ovf is a same-cycle event for the sticky error.
module oflow_buf_wr_frame_cnt
  import oflow_buf_wr_pkg::*;
(
  input  logic              clk,
  input  logic              reset_N,
  input  logic              frame_start,
  input  logic [NBOX_W-1:0] num_of_bbox_in_frame,
  input  logic              add,
  input  logic [2:0]        add_n,
  output logic              frame_done,
  output logic              ovf
);

  logic [NBOX_W-1:0] cnt_q, cnt_d;
  logic [NBOX_W-1:0] cnt_base;
  logic [NBOX_W:0]   sum;
  logic              frame_done_q, frame_done_d;

  // frame_start clears first, so a group finishing alongside it lands in the new frame
  always_comb begin
    cnt_base     = frame_start ? '0 : cnt_q;
    sum          = {1'b0, cnt_base} + (NBOX_W+1)'(add_n);
    cnt_d        = cnt_base;
    frame_done_d = 1'b0;
    ovf          = 1'b0;
    if (add) begin
      if (sum == {1'b0, num_of_bbox_in_frame}) begin
        frame_done_d = 1'b1;
        cnt_d        = '0;
      end else if (sum > {1'b0, num_of_bbox_in_frame}) begin
        ovf   = 1'b1;
        cnt_d = num_of_bbox_in_frame;
      end else begin
        cnt_d = sum[NBOX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: rtl/oflow_buffer_fsm_write.sv
// Buffer-side write responder: captures a PE group and streams it into MEM.
// Define OFLOW_BUF_WR_PARITY_EN to add wr_parity on the write bus.
module oflow_buffer_fsm_write
  import oflow_buf_wr_pkg::*;
(
  input  logic              clk,
  input  logic              reset_N,
  input  logic              frame_start,
  input  logic [NBOX_W-1:0] num_of_bbox_in_frame,
  oflow_buf_wr_if.slave     wr,
  output logic              frame_done,
  output logic              busy,
  output logic              err
);

  wr_state_e             state_q, state_d;
  logic [1:0]            lane_q, lane_d;
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0] hold_q [GROUP_SIZE];
  logic [DATA_WIDTH-1:0] hold_d [GROUP_SIZE];
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  err_evt;
  logic                  add;
  logic                  ovf;
  logic [1:0]            lane_nx;
  logic [ADDR_WIDTH-1:0] req_addr;

  assign lane_nx  = lane_q + 2'd1;
  assign req_addr = buf_addr(wr.row_sel, wr.pe_sel);

  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    n_d       = n_q;
    base_d    = base_q;
    hold_d    = hold_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    done_d    = 1'b0;
    add       = 1'b0;
    err_evt   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr.ready_from_core) begin
          if (wr.pe_sel >= PE_LEN'(NUM_GROUPS_PER_ROW)) begin
            err_evt = 1'b1;
          end else begin
            for (int k = 0; k < GROUP_SIZE; k++)
              hold_d[k] = wr.pe_data[k*DATA_WIDTH +: DATA_WIDTH];
            n_d = (wr.remainder != 2'd0)
                ? {1'b0, wr.remainder} : 3'd4;
            base_d    = req_addr;
            lane_d    = 2'd0;
            wr_en_d   = 1'b1;
            wr_addr_d = req_addr;
            wr_data_d = wr.pe_data[DATA_WIDTH-1:0];
            state_d   = WRITE;
          end
        end
      end
      WRITE: begin
        err_evt = wr.ready_from_core;
        if ({1'b0, lane_q} + 3'd1 == n_q) begin
          done_d  = 1'b1;
          add     = 1'b1;
          state_d = DONE;
        end else begin
          lane_d    = lane_nx;
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + ADDR_WIDTH'(lane_nx);
          wr_data_d = hold_q[lane_nx];
        end
      end
      DONE: begin
        err_evt = wr.ready_from_core;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d = (frame_start ? 1'b0 : err_q) | err_evt | ovf;
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      n_q       <= '0;
      base_q    <= '0;
      hold_q    <= '{default: '0};
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      n_q       <= n_d;
      base_q    <= base_d;
      hold_q    <= hold_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  oflow_buf_wr_frame_cnt u_frame_cnt (
    .clk                  (clk),
    .reset_N              (reset_N),
    .frame_start          (frame_start),
    .num_of_bbox_in_frame (num_of_bbox_in_frame),
    .add                  (add),
    .add_n                (n_q),
    .frame_done           (frame_done),
    .ovf                  (ovf)
  );

`ifdef OFLOW_BUF_WR_PARITY_EN
  logic par_q, par_d;

  assign par_d = wr_en_d & (^wr_data_d);

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) par_q <= 1'b0;
    else          par_q <= par_d;
  end

  assign wr.wr_parity = par_q;
`endif

  assign wr.wr_en             = wr_en_q;
  assign wr.wr_addr           = wr_addr_q;
  assign wr.wr_data           = wr_data_q;
  assign wr.done_write_buffer = done_q;
  assign busy                 = (state_q != IDLE);
  assign err                  = err_q;

endmodule

// File: doc/oflow_buffer_fsm_write.md
Name: oflow_buffer_fsm_write

Overview:
Buffer-side responder to the core write-sequencing FSM. On each group request (ready_from_core with row_sel/pe_sel/remainder) it captures up to 4 bbox words from the selected PE group. It writes them one per cycle into the MEM buffer at a computed address, then pulses done_write_buffer so the core advances. It also counts bboxes per frame and flags frame completion and protocol errors.

Parameters:
ROW_LEN, 3, width of row_sel (max 6 rows)
PE_LEN, 5, width of pe_sel
PE_NUM, 24, PEs per row (row stride in buffer words)
GROUP_SIZE, 4, bboxes per PE group
DATA_WIDTH, 64, bbox word width
ADDR_WIDTH, 8, buffer address width
NUM_OF_BBOX_IN_FRAME_WIDTH, 8, width of num_of_bbox_in_frame

Ports:
clk  in  1  clock
reset_N  in  1  reset, asynchronous, active-low
frame_start  in  1  one-cycle pulse; clears frame counter and error
num_of_bbox_in_frame  in  NUM_OF_BBOX_IN_FRAME_WIDTH  expected bboxes this frame
ready_from_core  in  1  one-cycle group request
row_sel  in  ROW_LEN  row of requested group
pe_sel  in  PE_LEN  group index in row (0..PE_NUM/GROUP_SIZE-1)
remainder  in  2  0 = full group of 4; 1..3 = partial group of that many bboxes
pe_data  in  GROUP_SIZE*DATA_WIDTH  lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_WIDTH  buffer write address
wr_data  out  DATA_WIDTH  buffer write data
done_write_buffer  out  1  one-cycle pulse, group written
frame_done  out  1  one-cycle pulse, frame count reached
busy  out  1  high outside IDLE
err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; holding regs 0.
- States: IDLE, WRITE, DONE.
- IDLE: on ready_from_core, capture pe_data into 4-entry hold, n = remainder ? remainder : 4, base = row_sel*PE_NUM + pe_sel*GROUP_SIZE (ADDR_WIDTH, truncated), lane = 0 -> WRITE.
- WRITE: wr_en=1, wr_addr=base+lane, wr_data=hold[lane]; lane++; when lane==n-1 -> DONE.
- DONE: done_write_buffer=1 for one cycle; frame_cnt += n. If the new frame_cnt equals num_of_bbox_in_frame, frame_done=1 in the same cycle and frame_cnt clears. -> IDLE.
- Latency: request at cycle T -> writes T+1..T+n -> done at T+n+1. Next request is accepted from cycle T+n+2 (IDLE).
- ready_from_core while busy: ignored (no capture) and err set.
- pe_sel >= PE_NUM/GROUP_SIZE at request: err set; request is still ignored, no writes, no done.
- frame_cnt exceeding num_of_bbox_in_frame (frame_cnt + n > num): err set, frame_cnt saturates at num, no frame_done.
- frame_start: clears frame_cnt and err. If it arrives mid-group, the group in flight still completes; its n counts toward the new frame. frame_start and a DONE in the same cycle: clear wins, then add n.
- num_of_bbox_in_frame = 0: frame_done never fires.
- Asynchronous reset mid-group: immediate return to IDLE, no done pulse.
- busy = (state != IDLE).

Optional Feature:
OFLOW_BUF_WR_PARITY_EN: adds output wr_parity (1 bit) = even-parity XOR of wr_data, valid when wr_en; 0 otherwise and at reset. Without the macro the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package oflow_buf_wr_pkg: state enum (IDLE, WRITE, DONE), PE_NUM, GROUP_SIZE, NUM_GROUPS_PER_ROW = PE_NUM/GROUP_SIZE, address-compute function.
- One sub-module: oflow_buf_wr_frame_cnt, holding the frame counter, compare/saturate, frame_done and overflow error.

Test Plan:
- num=8; requests (row0,pe0,rem0) then (row0,pe1,rem0) -> writes addr 0..3 then 4..7, done at T+5 each, frame_done with the second done.
- num=26; full row (6 requests rem0) then (row1,pe0,rem2) -> last writes addr 24,25, done at T+3, frame_done pulses.
- Request (row2,pe5,rem3) -> writes addr 68,69,70 with lanes 0..2; lane 3 never written.
- Second ready_from_core at T+2 during WRITE -> ignored, err=1, original group completes normally.
- pe_sel=6 request -> no wr_en, no done, err=1; frame_start clears err to 0.
- reset_N low at T+2 of a group -> outputs 0 immediately; a new request after release writes from lane 0 correctly.
